// File: rtl/fact_mmio_responder.sv
// Memory-mapped factorial unit: CTRL/N/STATUS/RESULT register file plus an
// iterative multiply FSM that computes N! and raises a level interrupt on completion.
`timescale 1ns/1ps
module fact_mmio_responder #(
    parameter int N_WIDTH   = 4,
    parameter int RES_WIDTH = 32,
    parameter int MAX_N     = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done_irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MULT,
        ST_FIN
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_N      = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    localparam logic [N_WIDTH-1:0]   MAX_N_V = N_WIDTH'(MAX_N);
    localparam logic [N_WIDTH-1:0]   CNT_ONE = N_WIDTH'(1);
    localparam logic [RES_WIDTH-1:0] RES_ONE = RES_WIDTH'(1);

    state_t                 state_reg,  state_next;
    logic [N_WIDTH-1:0]     n_reg,      n_next;
    logic [N_WIDTH-1:0]     cnt_reg,    cnt_next;
    logic [RES_WIDTH-1:0]   result_reg, result_next;
    logic                   ie_reg,     ie_next;
    logic                   done_reg,   done_next;
    logic                   err_reg,    err_next;

    logic busy;
    logic ctrl_wr;
    logic n_wr;
    logic go;
    logic clr;

    // Bits outside the decoded fields are deliberately don't-care.
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:N_WIDTH]};

    assign busy    = (state_reg == ST_LOAD) || (state_reg == ST_MULT);
    assign ctrl_wr = we && (addr[3:2] == REG_CTRL);
    assign n_wr    = we && (addr[3:2] == REG_N);
    assign go      = ctrl_wr && wdata[0];
    assign clr     = ctrl_wr && wdata[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            n_reg      <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            ie_reg     <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            n_reg      <= n_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            ie_reg     <= ie_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        n_next      = n_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        ie_next     = ie_reg;
        done_next   = done_reg;
        err_next    = err_reg;

        // IE is updated by every CTRL write regardless of FSM state.
        if (ctrl_wr) begin
            ie_next = wdata[2];
        end
        if (n_wr && !busy) begin
            n_next = wdata[N_WIDTH-1:0];
        end

        case (state_reg)
            ST_IDLE, ST_FIN: begin
                // GO takes priority over CLR when both arrive in one write.
                if (go) begin
                    done_next = 1'b0;
                    err_next  = 1'b0;
                    if (n_reg > MAX_N_V) begin
                        err_next    = 1'b1;
                        done_next   = 1'b1;
                        result_next = '0;
                        state_next  = ST_FIN;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end else if (clr && (state_reg == ST_FIN)) begin
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                result_next = RES_ONE;
                cnt_next    = n_reg;
                state_next  = ST_MULT;
            end
            ST_MULT: begin
                if (cnt_reg > CNT_ONE) begin
                    result_next = result_reg * RES_WIDTH'(cnt_reg);
                    cnt_next    = cnt_reg - CNT_ONE;
                end else begin
                    done_next  = 1'b1;
                    state_next = ST_FIN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        case (addr[3:2])
            REG_CTRL:   rdata = {29'b0, ie_reg, 2'b00};
            REG_N:      rdata = 32'(n_reg);
            REG_STATUS: rdata = {29'b0, busy, err_reg, done_reg};
            REG_RESULT: rdata = 32'(result_reg);
            default:    rdata = '0;
        endcase
    end

    assign done_irq = done_reg & ie_reg;

endmodule

// File: tb/tb_fact_mmio_responder.sv
// Randomized self-checking bench for fact_mmio_responder; expected values come
// from a plain-arithmetic factorial model and the documented completion latency.
`timescale 1ns/1ps
module tb_fact_mmio_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done_irq;

    int n_checks = 0;
    int n_fail   = 0;

    fact_mmio_responder #(
        .N_WIDTH  (4),
        .RES_WIDTH(32),
        .MAX_N    (12)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .done_irq(done_irq)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fact_ref(input int n);
        logic [31:0] r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * 32'(i);
        return r;
    endfunction

    // Random upper and byte-lane bits must not affect decoding.
    function automatic logic [31:0] mk_addr(input int idx);
        logic [31:0] r = $urandom();
        logic [1:0]  i2 = 2'(idx);
        return {r[31:4], i2, r[1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        $display("[%0t] write reg=%0d data=0x%08h", $time, a[3:2], d);
    endtask

    task automatic bus_read(input int idx, output logic [31:0] d);
        we = 1'b0;
        addr = mk_addr(idx);
        #1;
        d = rdata;
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(idx, d);
        check_val(tag, d, exp);
    endtask

    // Writes N, issues GO (optionally with CLR), checks BUSY for the whole
    // max(N,1)+1 cycle window and the final result/interrupt.
    task automatic run_fact(input int n, input bit ie, input bit clr);
        int lat;
        bus_write(mk_addr(1), 32'(n));
        bus_write(mk_addr(0), {29'b0, ie, clr, 1'b1});
        if (n > 12) begin
            check_reg("err_status", 2, 32'h3);
            check_reg("err_result", 3, 32'h0);
            check_val("err_irq", 32'(done_irq), 32'(ie));
            $display("[%0t] txn N=%0d ie=%0d -> error", $time, n, ie);
            return;
        end
        lat = ((n < 1) ? 1 : n) + 1;
        for (int j = 0; j < lat; j++) begin
            if (j > 0) tick();
            check_reg("busy_status", 2, 32'h4);
            check_val("busy_irq", 32'(done_irq), 32'h0);
        end
        tick();
        check_reg("done_status", 2, 32'h1);
        check_reg("done_result", 3, fact_ref(n));
        check_val("done_irq", 32'(done_irq), 32'(ie));
        check_reg("n_readback", 1, 32'(n));
        check_reg("ctrl_readback", 0, {29'b0, ie, 2'b00});
        $display("[%0t] txn N=%0d ie=%0d -> %0d after %0d cycles", $time, n, ie, fact_ref(n), lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        #1;
        check_reg("rst_ctrl", 0, 32'h0);
        check_reg("rst_n", 1, 32'h0);
        check_reg("rst_status", 2, 32'h0);
        check_reg("rst_result", 3, 32'h0);
        check_val("rst_irq", 32'(done_irq), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic cases and the N=0/1/12 boundaries.
        run_fact(5, 1'b1, 1'b0);
        run_fact(12, 1'b0, 1'b0);
        run_fact(0, 1'b1, 1'b0);
        run_fact(1, 1'b1, 1'b0);

        // Out-of-range N, then CLR back to idle (IE cleared by the same write).
        run_fact(13, 1'b1, 1'b0);
        bus_write(mk_addr(0), 32'h2);
        check_reg("clr_status", 2, 32'h0);
        check_reg("clr_ctrl", 0, 32'h0);
        check_val("clr_irq", 32'(done_irq), 32'h0);

        // Writes of N and GO while busy are ignored.
        bus_write(mk_addr(1), 32'd7);
        bus_write(mk_addr(0), 32'h5);
        bus_write(mk_addr(1), 32'd3);
        bus_write(mk_addr(0), 32'h5);
        for (int j = 0; j < 5; j++) begin
            tick();
            check_reg("ign_busy", 2, 32'h4);
        end
        tick();
        check_reg("ign_status", 2, 32'h1);
        check_reg("ign_result", 3, 32'd5040);
        check_reg("ign_n", 1, 32'd7);
        $display("[%0t] txn N=7 with ignored busy writes", $time);

        // GO+CLR from FIN restarts.
        run_fact(4, 1'b1, 1'b1);

        // Randomized transactions against the model.
        for (int it = 0; it < 24; it++) begin
            int  n  = $urandom_range(0, 15);
            bit  ie = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                bus_write(mk_addr(0), {29'b0, ie, 2'b10});
                check_reg("rnd_clr_status", 2, 32'h0);
                check_val("rnd_clr_irq", 32'(done_irq), 32'h0);
            end
            run_fact(n, ie, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of N=9 clears everything at once.
        bus_write(mk_addr(1), 32'd9);
        bus_write(mk_addr(0), 32'h5);
        repeat (4) tick();
        check_reg("partial_result", 3, 32'd504);
        #2;
        rst = 1'b1;
        #1;
        check_reg("arst_status", 2, 32'h0);
        check_reg("arst_result", 3, 32'h0);
        check_reg("arst_n", 1, 32'h0);
        check_reg("arst_ctrl", 0, 32'h0);
        check_val("arst_irq", 32'(done_irq), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        check_reg("post_rst_status", 2, 32'h0);
        check_reg("post_rst_result", 3, 32'h0);
        $display("[%0t] txn reset during N=9", $time);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
